// File: rtl/simon_decrypt.sv
// simon_decrypt: iterative SIMON 128/256 decryption core, one round per clock.
// Optional SIMON_DEC_KEYCACHE_EN keeps the last expanded key window so a repeated key skips EXPAND.
module simon_decrypt #(
  parameter int ROUNDS = 72,
  parameter int WORD   = 64
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic [4*WORD-1:0] keys,
  input  logic [2*WORD-1:0] ct,
  output logic [2*WORD-1:0] pt,
  output logic              done,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_e;

  localparam logic [WORD-1:0] C        = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [61:0]     Z4       = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [6:0]      LAST_EXP = 7'(ROUNDS - 5);
  localparam logic [6:0]      LAST_RND = 7'(ROUNDS - 1);

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int s);
    return (v << s) | (v >> (WORD - s));
  endfunction

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int s);
    return (v >> s) | (v << (WORD - s));
  endfunction

  function automatic logic [WORD-1:0] fr(input logic [WORD-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // z[0] is the leftmost (MSB) character of the sequence, index taken mod 62
  function automatic logic zbit(input logic [6:0] i);
    logic [6:0] j;
    logic [5:0] b;
    j = (i >= 7'd62) ? i - 7'd62 : i;
    b = 6'(7'd61 - j);
    return Z4[b];
  endfunction

  state_e               state_q;
  logic [6:0]           cnt_q;
  logic [3:0][WORD-1:0] win_q;
  logic [WORD-1:0]      x_q, y_q;
  logic [2*WORD-1:0]    pt_q;
  logic                 done_q, busy_q;

  logic [WORD-1:0]      tmp_f_d, tmp_b_d, k_fwd_d, k_bwd_d, y_inv_d;
  logic [6:0]           zb_idx_d;

  // win_q[0] is the oldest key; forward steps append at [3], backward steps at [0]
  always_comb begin
    tmp_f_d  = ror(win_q[3], 3) ^ win_q[1];
    k_fwd_d  = C ^ WORD'(zbit(cnt_q)) ^ win_q[0] ^ tmp_f_d ^ ror(tmp_f_d, 1);
    tmp_b_d  = ror(win_q[2], 3) ^ win_q[0];
    zb_idx_d = (cnt_q >= 7'd4) ? cnt_q - 7'd4 : 7'd0;
    k_bwd_d  = win_q[3] ^ C ^ WORD'(zbit(zb_idx_d)) ^ tmp_b_d ^ ror(tmp_b_d, 1);
    y_inv_d  = x_q ^ fr(y_q) ^ win_q[3];
  end

  logic                 hit;
  logic [3:0][WORD-1:0] cache_win;

`ifdef SIMON_DEC_KEYCACHE_EN
  logic                 cache_vld_q;
  logic [4*WORD-1:0]    cache_tag_q, key_q;
  logic [3:0][WORD-1:0] cache_win_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cache_vld_q <= 1'b0;
      cache_tag_q <= '0;
      cache_win_q <= '0;
      key_q       <= '0;
    end else begin
      if ((state_q == IDLE || state_q == DONE) && start)
        key_q <= keys;
      if (state_q == EXPAND && cnt_q == LAST_EXP) begin
        cache_vld_q <= 1'b1;
        cache_tag_q <= key_q;
        cache_win_q <= {k_fwd_d, win_q[3:1]};
      end
    end
  end

  assign hit       = cache_vld_q && (keys == cache_tag_q);
  assign cache_win = cache_win_q;
`else
  assign hit       = 1'b0;
  assign cache_win = '0;
`endif

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x_q    <= ct[2*WORD-1:WORD];
            y_q    <= ct[WORD-1:0];
            done_q <= 1'b0;
            busy_q <= 1'b1;
            if (hit) begin
              win_q   <= cache_win;
              cnt_q   <= LAST_RND;
              state_q <= DECRYPT;
            end else begin
              win_q   <= keys;
              cnt_q   <= '0;
              state_q <= EXPAND;
            end
          end
        end
        EXPAND: begin
          win_q <= {k_fwd_d, win_q[3:1]};
          if (cnt_q == LAST_EXP) begin
            cnt_q   <= LAST_RND;
            state_q <= DECRYPT;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        DECRYPT: begin
          x_q   <= y_q;
          y_q   <= y_inv_d;
          win_q <= {win_q[2:0], k_bwd_d};
          if (cnt_q == 7'd0) begin
            pt_q    <= {y_q, y_inv_d};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 7'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pt   = pt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed bench for simon_decrypt: known-answer vector, round trips through a reference
// encryptor, busy protection, mid-run reset, back-to-back launch and the optional key cache.
module tb_simon_decrypt;
  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] keys = '0;
  logic [127:0] ct = '0;
  logic [127:0] pt;
  logic         done, busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int lat_exp = 140;

  localparam logic [255:0] KAT_KEY = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KAT_CT  = 128'h8d2b5579afc8a3a03bf72a87efe7b868;
  localparam logic [127:0] KAT_PT  = 128'h74206e69206d6f6f6d69732061207369;
  localparam logic [127:0] PT2     = 128'h0011223344556677_8899aabbccddeeff;
  localparam logic [61:0]  ZSEQ    = 62'b11010001111001101011011000100000010111000011001010010011101111;

`ifdef SIMON_DEC_KEYCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic [255:0] mc_tag = '0;
  logic         mc_vld = 1'b0;

  simon_decrypt dut (
    .clk(clk), .res_n(res_n), .start(start), .keys(keys), .ct(ct),
    .pt(pt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  // Reference SIMON 128/256 encryption, written in the ~k ^ 3 key-schedule form.
  function automatic logic [127:0] enc(input logic [255:0] key, input logic [127:0] p);
    logic [63:0] k [72];
    logic [63:0] x, y, t;
    logic [61:0] tz;
    for (int i = 0; i < 4; i++) k[i] = key[64*i +: 64];
    for (int i = 0; i < 68; i++) begin
      tz = ZSEQ >> (61 - (i % 62));
      t  = rotr(k[i+3], 3) ^ k[i+1];
      t  = t ^ rotr(t, 1);
      k[i+4] = ~k[i] ^ t ^ {63'd0, tz[0]} ^ 64'd3;
    end
    x = p[127:64];
    y = p[63:0];
    for (int i = 0; i < 72; i++) begin
      t = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic int exp_lat(input logic [255:0] k);
    return (CACHE_ON && mc_vld && k == mc_tag) ? 72 : 140;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    res_n = 1'b0;
    @(posedge clk);
    #1;
    mc_vld = 1'b0;
  endtask

  task automatic release_reset;
    @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic launch(input logic [255:0] k, input logic [127:0] c);
    @(negedge clk);
    keys = k;
    ct = c;
    start = 1'b1;
    lat_exp = exp_lat(k);
    mc_tag = k;
    mc_vld = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int lat);
    while (!done && (cyc - t0) < 400) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - t0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (pt !== 128'h0) begin n_fail++; $display("FAIL reset_pt: got %h expected 0", pt); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    release_reset();
  endtask

  task automatic test_kat;
    int lat;
    launch(KAT_KEY, KAT_CT);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kat_busy_run: got %b expected 1", busy); end
    wait_done(lat);
    n_chk++; if (lat !== lat_exp) begin n_fail++; $display("FAIL kat_latency: got %0d expected %0d", lat, lat_exp); end
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL kat_pt: got %h expected %h", pt, KAT_PT); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kat_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [127:0] c2;
    c2 = enc(KAT_KEY, PT2);
    launch(KAT_KEY, c2);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
    wait_rel(50);
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL b2b_pt_held: got %h expected %h", pt, KAT_PT); end
    wait_done(lat);
    n_chk++; if (lat !== lat_exp) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, lat_exp); end
    n_chk++; if (pt !== PT2) begin n_fail++; $display("FAIL b2b_pt: got %h expected %h", pt, PT2); end
  endtask

  task automatic test_busy_protect;
    int lat;
    launch(KAT_KEY, KAT_CT);
    wait_rel(29);
    @(negedge clk);
    start = 1'b1;
    ct = ~KAT_CT;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid: got %b expected 1", busy); end
    wait_rel(59);
    @(negedge clk);
    keys = ~KAT_KEY;
    ct = 128'h0;
    wait_done(lat);
    n_chk++; if (lat !== lat_exp) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", lat, lat_exp); end
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL busy_pt: got %h expected %h", pt, KAT_PT); end
  endtask

  task automatic test_reset_mid;
    int lat;
    launch(KAT_KEY, enc(KAT_KEY, PT2));
    wait_rel(49);
    do_reset();
    n_chk++; if (pt !== 128'h0) begin n_fail++; $display("FAIL rstmid_pt: got %h expected 0", pt); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    release_reset();
    launch(KAT_KEY, KAT_CT);
    wait_done(lat);
    n_chk++; if (lat !== 140) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 140", lat); end
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL rstmid_pt_after: got %h expected %h", pt, KAT_PT); end
  endtask

  task automatic test_roundtrip;
    int lat;
    logic [255:0] kv [3];
    logic [127:0] pv [3];
    kv[0] = 256'h0; pv[0] = 128'h0;
    kv[1] = 256'h1; pv[1] = 128'h0;
    kv[2] = KAT_KEY ^ {4{64'h0123_4567_89ab_cdef}}; pv[2] = PT2;
    for (int i = 0; i < 3; i++) begin
      launch(kv[i], enc(kv[i], pv[i]));
      wait_done(lat);
      n_chk++; if (lat !== lat_exp) begin n_fail++; $display("FAIL rt%0d_latency: got %0d expected %0d", i, lat, lat_exp); end
      n_chk++; if (pt !== pv[i]) begin n_fail++; $display("FAIL rt%0d_pt: got %h expected %h", i, pt, pv[i]); end
    end
  endtask

`ifdef SIMON_DEC_KEYCACHE_EN
  task automatic test_keycache;
    int lat;
    do_reset();
    release_reset();
    launch(KAT_KEY, KAT_CT);
    wait_done(lat);
    n_chk++; if (lat !== 140) begin n_fail++; $display("FAIL kc_first_latency: got %0d expected 140", lat); end
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL kc_first_pt: got %h expected %h", pt, KAT_PT); end
    launch(KAT_KEY, enc(KAT_KEY, PT2));
    wait_done(lat);
    n_chk++; if (lat !== 72) begin n_fail++; $display("FAIL kc_hit_latency: got %0d expected 72", lat); end
    n_chk++; if (pt !== PT2) begin n_fail++; $display("FAIL kc_hit_pt: got %h expected %h", pt, PT2); end
    launch(256'h0, enc(256'h0, 128'h0));
    wait_done(lat);
    n_chk++; if (lat !== 140) begin n_fail++; $display("FAIL kc_miss_latency: got %0d expected 140", lat); end
    n_chk++; if (pt !== 128'h0) begin n_fail++; $display("FAIL kc_miss_pt: got %h expected 0", pt); end
    do_reset();
    release_reset();
    launch(KAT_KEY, KAT_CT);
    wait_done(lat);
    n_chk++; if (lat !== 140) begin n_fail++; $display("FAIL kc_post_reset_latency: got %0d expected 140", lat); end
    n_chk++; if (pt !== KAT_PT) begin n_fail++; $display("FAIL kc_post_reset_pt: got %h expected %h", pt, KAT_PT); end
  endtask
`endif

  initial begin
    test_reset();
    test_kat();
    test_back_to_back();
    test_busy_protect();
    test_reset_mid();
    test_roundtrip();
`ifdef SIMON_DEC_KEYCACHE_EN
    test_keycache();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
